mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Consumer end of the EX/MEM pipeline register. Takes the registered EX outputs and performs data-memory access for loads and stores.
- Drives a req/ack data-memory port and stalls upstream stages while an access is outstanding.
- Registers the MEM/WB outputs: ALU pass-through, or aligned and extended load data.
- Non-memory instructions pass through with 1-cycle latency.

Parameters:
ACK_TIMEOUT, 255, max cycles in ACCESS waiting for dmem_ack before abort; 0 disables the timeout.

Ports:
clk  in  1  pipeline clock, rising edge
reset  in  1  asynchronous, active-low (0 = reset)
EX_instr  in  32  instruction; funct3 = EX_instr[14:12]
EX_rd  in  5  destination register index
EX_opcode  in  7  load = 7'b0000011, store = 7'b0100011, others pass through
EX_regwrite  in  1  writeback enable
EX_r2  in  32  store data
EX_alu_result  in  32  effective address, or ALU result
mem_stall  out  1  combinational; upstream holds all EX_* stable while 1
dmem_req  out  1  registered request
dmem_we  out  1  1 = store
dmem_addr  out  32  word address {addr[31:2],2'b00}
dmem_wdata  out  32  lane-replicated store data
dmem_wstrb  out  4  byte enables (0 on loads)
dmem_ack  in  1  access complete; rdata valid in the same cycle
dmem_rdata  in  32  read word
MEM_instr, MEM_rd, MEM_opcode, MEM_regwrite, MEM_alu_result  out  32/5/7/1/32  registered copies of the EX fields
MEM_load_data  out  32  extended load result (0 for non-loads)
MEM_fault  out  1  one-cycle pulse on misaligned access, illegal funct3, or timeout

Behaviour:
- Reset (reset=0, async): state=IDLE; all outputs and internal registers 0; timeout counter 0.
  - An outstanding dmem_req drops immediately; the memory abandons the transfer.
- States: IDLE, ACCESS.
- memop = load or store opcode.
- Legal funct3:
  - Load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Store: 000 SB, 001 SH, 010 SW.
- fault = illegal funct3, OR halfword with addr[0]=1, OR word with addr[1:0]!=0.
- IDLE, non-memop:
  - Next edge: MEM_* <= EX_*; MEM_load_data <= 0; mem_stall = 0.
- IDLE, memop with fault:
  - No request issued; mem_stall = 0.
  - Next edge: bubble (MEM_instr=0, MEM_opcode=0, MEM_rd=0, MEM_regwrite=0); MEM_fault=1 for one cycle.
- IDLE, memop without fault:
  - mem_stall = 1 combinationally.
  - Next edge: latch dmem_addr/we/wdata/wstrb, dmem_req <= 1, state <= ACCESS, MEM_* <= bubble.
- ACCESS:
  - mem_stall = !dmem_ack; MEM_* hold bubble; request fields stay constant while dmem_req=1.
  - dmem_ack is ignored in IDLE.
- ACCESS, on dmem_ack=1:
  - Next edge: dmem_req <= 0; state <= IDLE; MEM_* <= EX_*; MEM_load_data <= formatted rdata (loads only).
  - The pipeline advances at this edge because mem_stall=0 in that cycle.
  - Minimum memop latency: 2 cycles from EX presentation to MEM output, with ack in the first ACCESS cycle.
- Store formatting (lane = addr[1:0]):
  - SB: wdata = {4{r2[7:0]}}, wstrb = 4'b0001<<lane.
  - SH: wdata = {2{r2[15:0]}}, wstrb = 4'b0011<<lane.
  - SW: wdata = r2, wstrb = 4'b1111.
- Load formatting:
  - Byte = rdata[8*lane +: 8]; half = rdata[16*addr[1] +: 16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW full word.
- Timeout:
  - Counter clears on entering ACCESS and increments each ACCESS cycle without ack.
  - When count == ACK_TIMEOUT-1 and there is no ack (ACK_TIMEOUT≠0): next edge drops dmem_req, returns to IDLE, outputs bubble, pulses MEM_fault.
  - mem_stall=0 in that cycle.
- Ack in the same cycle as timeout expiry: the ack wins; the access completes normally and there is no fault.
- Stores: MEM_regwrite forwards EX_regwrite unchanged; decode is expected to set it to 0.

Test Plan:
- ADD (opcode 0110011), alu_result=32'h1234, rd=5, regwrite=1 -> next cycle MEM_alu_result=32'h1234, MEM_rd=5, MEM_regwrite=1, mem_stall=0, dmem_req=0.
- LB, addr=32'h103, ack 3 cycles after req, rdata=32'h80FF_7F01 -> dmem_addr=32'h100, wstrb=0; mem_stall high until the ack cycle; MEM_load_data=32'hFFFFFF80.
  - Repeat with LBU -> MEM_load_data=32'h00000080.
- SH, addr=32'h22, r2=32'hDEADBEEF, ack in the first ACCESS cycle -> dmem_we=1, wdata=32'hBEEFBEEF, wstrb=4'b1100; total 2-cycle latency.
- LW at addr=32'h6 -> no dmem_req; MEM_fault=1 for 1 cycle; MEM_regwrite=0; mem_stall=0.
- ACK_TIMEOUT=4, LW aligned, never ack -> dmem_req high for 4 cycles, then low; MEM_fault pulses; state returns to IDLE.
  - Same setup with ack on the 4th cycle -> normal completion, no fault.
- reset driven to 0 mid-ACCESS (asynchronous, between edges) -> dmem_req and all MEM_* go to 0 immediately.
  - After release, an ADD passes with 1-cycle latency.

Source files
------------

// File: rtl/mem_stage_if.sv
// Data-memory port between the MEM stage (master) and the data memory (slave).
// dmem_req rises with stable addr/we/wdata/wstrb and holds them until the cycle dmem_ack is seen;
// that cycle completes the transfer (rdata valid alongside ack) and req drops at the next edge.
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues loads/stores on the data-memory port, stalls upstream while an
// access is outstanding, and registers the MEM/WB fields (pass-through or formatted load data).
module mem_stage #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] EX_instr,
  input  logic [4:0]  EX_rd,
  input  logic [6:0]  EX_opcode,
  input  logic        EX_regwrite,
  input  logic [31:0] EX_r2,
  input  logic [31:0] EX_alu_result,
  output logic        mem_stall,
  mem_stage_if.master dmem,
  output logic [31:0] MEM_instr,
  output logic [4:0]  MEM_rd,
  output logic [6:0]  MEM_opcode,
  output logic        MEM_regwrite,
  output logic [31:0] MEM_alu_result,
  output logic [31:0] MEM_load_data,
  output logic        MEM_fault,
  output logic        dbg_state_o
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam bit         TO_EN    = (ACK_TIMEOUT != 0);
  localparam int         CNT_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(ACK_TIMEOUT - 1) : '0;

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              req_q, we_q;
  logic [31:0]       addr_q, wdata_q;
  logic [3:0]        wstrb_q;
  logic [31:0]       instr_q, alu_q, load_q;
  logic [4:0]        rd_q;
  logic [6:0]        opcode_q;
  logic              regwrite_q, fault_q;

  logic [2:0]  f3;
  logic [1:0]  lane;
  logic        is_load, is_store, memop, legal_f3, misalign, fault;
  logic [31:0] st_wdata, ld_data;
  logic [3:0]  st_wstrb;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        timeout_hit;
  logic        do_pass, do_issue, do_done, do_expire, do_fault;

  always_comb begin
    f3       = EX_instr[14:12];
    lane     = EX_alu_result[1:0];
    is_load  = (EX_opcode == OP_LOAD);
    is_store = (EX_opcode == OP_STORE);
    memop    = is_load || is_store;
    legal_f3 = is_load ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})
                       : (f3 inside {3'd0, 3'd1, 3'd2});
    misalign = ((f3[1:0] == 2'b01) && lane[0]) ||
               ((f3[1:0] == 2'b10) && (lane != 2'b00));
    fault    = memop && (!legal_f3 || misalign);
  end

  always_comb begin
    st_wdata = EX_r2;
    st_wstrb = 4'b1111;
    case (f3[1:0])
      2'b00: begin
        st_wdata = {4{EX_r2[7:0]}};
        st_wstrb = 4'b0001 << lane;
      end
      2'b01: begin
        st_wdata = {2{EX_r2[15:0]}};
        st_wstrb = 4'b0011 << lane;
      end
      default: ;
    endcase
    if (!is_store) st_wstrb = 4'b0000;
  end

  // EX_* are held stable through ACCESS, so the load is formatted from the live EX fields.
  always_comb begin
    ld_byte = dmem.dmem_rdata[{lane, 3'b000} +: 8];
    ld_half = dmem.dmem_rdata[{EX_alu_result[1], 4'b0000} +: 16];
    case (f3)
      3'd0:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'd1:    ld_data = {{16{ld_half[15]}}, ld_half};
      3'd2:    ld_data = dmem.dmem_rdata;
      3'd4:    ld_data = {24'h0, ld_byte};
      3'd5:    ld_data = {16'h0, ld_half};
      default: ld_data = 32'h0;
    endcase
  end

  assign timeout_hit = TO_EN && (state_q == ACCESS) && !dmem.dmem_ack && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (memop && !fault) state_d = ACCESS;
      ACCESS: if (dmem.dmem_ack || timeout_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_stall = 1'b0;
    do_pass   = 1'b0;
    do_issue  = 1'b0;
    do_done   = 1'b0;
    do_expire = 1'b0;
    do_fault  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!memop)     do_pass  = 1'b1;
        else if (fault) do_fault = 1'b1;
        else begin
          do_issue  = 1'b1;
          mem_stall = 1'b1;
        end
      end
      ACCESS: begin
        if (dmem.dmem_ack)    do_done   = 1'b1;
        else if (timeout_hit) do_expire = 1'b1;
        else                  mem_stall = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q      <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      wstrb_q    <= 4'h0;
      instr_q    <= 32'h0;
      rd_q       <= 5'h0;
      opcode_q   <= 7'h0;
      regwrite_q <= 1'b0;
      alu_q      <= 32'h0;
      load_q     <= 32'h0;
      fault_q    <= 1'b0;
    end else begin
      if (do_issue)                                     cnt_q <= '0;
      else if (state_q == ACCESS && !dmem.dmem_ack && !timeout_hit) cnt_q <= cnt_q + CNT_W'(1);

      if (do_issue) begin
        req_q   <= 1'b1;
        we_q    <= is_store;
        addr_q  <= {EX_alu_result[31:2], 2'b00};
        wdata_q <= st_wdata;
        wstrb_q <= st_wstrb;
      end else if (do_done || do_expire) begin
        req_q   <= 1'b0;
      end

      if (do_pass || do_done) begin
        instr_q    <= EX_instr;
        rd_q       <= EX_rd;
        opcode_q   <= EX_opcode;
        regwrite_q <= EX_regwrite;
        alu_q      <= EX_alu_result;
        load_q     <= (do_done && is_load) ? ld_data : 32'h0;
      end else begin
        instr_q    <= 32'h0;
        rd_q       <= 5'h0;
        opcode_q   <= 7'h0;
        regwrite_q <= 1'b0;
        alu_q      <= 32'h0;
        load_q     <= 32'h0;
      end

      fault_q <= do_fault || do_expire;
    end
  end

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;
  assign dmem.dmem_wstrb = wstrb_q;

  assign MEM_instr      = instr_q;
  assign MEM_rd         = rd_q;
  assign MEM_opcode     = opcode_q;
  assign MEM_regwrite   = regwrite_q;
  assign MEM_alu_result = alu_q;
  assign MEM_load_data  = load_q;
  assign MEM_fault      = fault_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a transaction-level model predicts each MEM/WB edge and the
// request fields; a compare process checks the registered outputs after every predicted edge.
module tb_mem_stage;
  localparam int         TO       = 4;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ADD   = 7'b0110011;

  typedef struct packed {
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [6:0]  opcode;
    logic        regwrite;
    logic [31:0] alu;
    logic [31:0] load_data;
    logic        fault;
    logic        bubble;
  } mem_rec_t;

  logic        clk;
  logic        reset;
  logic [31:0] EX_instr, EX_r2, EX_alu_result;
  logic [4:0]  EX_rd;
  logic [6:0]  EX_opcode;
  logic        EX_regwrite;
  logic        mem_stall;
  logic [31:0] MEM_instr, MEM_alu_result, MEM_load_data;
  logic [4:0]  MEM_rd;
  logic [6:0]  MEM_opcode;
  logic        MEM_regwrite, MEM_fault, dbg_state;

  mem_stage_if bus ();

  mem_stage #(.ACK_TIMEOUT(TO)) dut (
    .clk            (clk),
    .reset          (reset),
    .EX_instr       (EX_instr),
    .EX_rd          (EX_rd),
    .EX_opcode      (EX_opcode),
    .EX_regwrite    (EX_regwrite),
    .EX_r2          (EX_r2),
    .EX_alu_result  (EX_alu_result),
    .mem_stall      (mem_stall),
    .dmem           (bus),
    .MEM_instr      (MEM_instr),
    .MEM_rd         (MEM_rd),
    .MEM_opcode     (MEM_opcode),
    .MEM_regwrite   (MEM_regwrite),
    .MEM_alu_result (MEM_alu_result),
    .MEM_load_data  (MEM_load_data),
    .MEM_fault      (MEM_fault),
    .dbg_state_o    (dbg_state)
  );

  int          n_vec = 0;
  int          n_err = 0;
  mem_rec_t    exp_q[$];
  int          last_lat, last_req_cycles;
  logic [31:0] last_addr, last_wdata;
  logic [3:0]  last_wstrb;
  logic        last_we;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit m_fault(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] a);
    bit legal;
    int size;
    if (opc != OP_LOAD && opc != OP_STORE) return 1'b0;
    if (opc == OP_LOAD) legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    else                legal = (f3 inside {3'd0, 3'd1, 3'd2});
    if (!legal) return 1'b1;
    size = 1 << f3[1:0];
    return (int'(a[1:0]) % size) != 0;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rdata);
    logic [31:0] sh;
    sh = rdata >> (8 * int'(a[1:0]));
    case (f3)
      3'd0:    return {{24{sh[7]}}, sh[7:0]};
      3'd1:    return {{16{sh[15]}}, sh[15:0]};
      3'd2:    return rdata;
      3'd4:    return {24'h0, sh[7:0]};
      3'd5:    return {16'h0, sh[15:0]};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] r2);
    case (f3)
      3'd0:    return {4{r2[7:0]}};
      3'd1:    return {2{r2[15:0]}};
      default: return r2;
    endcase
  endfunction

  function automatic logic [3:0] m_wstrb(input logic [2:0] f3, input logic [31:0] a);
    int nbytes;
    nbytes = 1 << f3[1:0];
    return 4'(((1 << nbytes) - 1) << int'(a[1:0]));
  endfunction

  function automatic mem_rec_t m_bubble(input logic flt);
    mem_rec_t r;
    r        = '0;
    r.fault  = flt;
    r.bubble = 1'b1;
    return r;
  endfunction

  // ---------------- compare process ----------------
  initial begin
    mem_rec_t r;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        r = exp_q.pop_front();
        check("MEM_instr",     MEM_instr,            r.instr);
        check("MEM_rd",        32'(MEM_rd),          32'(r.rd));
        check("MEM_opcode",    32'(MEM_opcode),      32'(r.opcode));
        check("MEM_regwrite",  32'(MEM_regwrite),    32'(r.regwrite));
        check("MEM_load_data", MEM_load_data,        r.load_data);
        check("MEM_fault",     32'(MEM_fault),       32'(r.fault));
        if (!r.bubble) check("MEM_alu_result", MEM_alu_result, r.alu);
      end
    end
  end

  // ---------------- driver ----------------
  // Called at a negedge; returns at the negedge after the edge where the pipeline advances.
  // ack_cycle: ACCESS cycle (1 = first) in which the memory acks; 0 = never.
  task automatic apply(input logic [2:0] f3, input logic [6:0] opc, input logic [4:0] rd,
                       input logic rw, input logic [31:0] r2, input logic [31:0] alu,
                       input int ack_cycle, input logic [31:0] rdata);
    mem_rec_t done;
    bit       memop, flt, finished;
    int       i;
    EX_instr      = {17'h0, f3, rd, opc};
    EX_opcode     = opc;
    EX_rd         = rd;
    EX_regwrite   = rw;
    EX_r2         = r2;
    EX_alu_result = alu;
    memop = (opc == OP_LOAD) || (opc == OP_STORE);
    flt   = m_fault(opc, f3, alu);
    done  = '{instr: EX_instr, rd: rd, opcode: opc, regwrite: rw, alu: alu,
              load_data: 32'h0, fault: 1'b0, bubble: 1'b0};
    last_lat = 0;
    last_req_cycles = 0;
    #1;
    if (!memop || flt) begin
      check("stall_idle", 32'(mem_stall), 32'h0);
      check("req_idle", 32'(bus.dmem_req), 32'h0);
      exp_q.push_back(flt ? m_bubble(1'b1) : done);
      last_lat = 1;
      @(negedge clk);
    end else begin
      check("stall_issue", 32'(mem_stall), 32'h1);
      check("req_before_issue", 32'(bus.dmem_req), 32'h0);
      exp_q.push_back(m_bubble(1'b0));
      last_lat = 1;
      @(negedge clk);
      i = 1;
      finished = 1'b0;
      while (!finished) begin
        check("dmem_req",   32'(bus.dmem_req),   32'h1);
        check("dmem_addr",  bus.dmem_addr,       {alu[31:2], 2'b00});
        check("dmem_we",    32'(bus.dmem_we),    32'(opc == OP_STORE));
        check("dmem_wstrb", 32'(bus.dmem_wstrb), (opc == OP_STORE) ? 32'(m_wstrb(f3, alu)) : 32'h0);
        if (opc == OP_STORE) check("dmem_wdata", bus.dmem_wdata, m_wdata(f3, r2));
        last_addr  = bus.dmem_addr;
        last_we    = bus.dmem_we;
        last_wdata = bus.dmem_wdata;
        last_wstrb = bus.dmem_wstrb;
        last_req_cycles++;
        if (i == ack_cycle) begin
          bus.dmem_ack   = 1'b1;
          bus.dmem_rdata = rdata;
          #1;
          check("stall_ack", 32'(mem_stall), 32'h0);
          if (opc == OP_LOAD) done.load_data = m_load(f3, alu, rdata);
          exp_q.push_back(done);
          finished = 1'b1;
        end else if (i == TO) begin
          #1;
          check("stall_timeout", 32'(mem_stall), 32'h0);
          exp_q.push_back(m_bubble(1'b1));
          finished = 1'b1;
        end else begin
          #1;
          check("stall_wait", 32'(mem_stall), 32'h1);
          exp_q.push_back(m_bubble(1'b0));
        end
        last_lat++;
        @(negedge clk);
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = 32'h0;
        i++;
      end
      #1;
      check("req_dropped", 32'(bus.dmem_req), 32'h0);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b0;
    EX_instr = 32'h0; EX_rd = 5'h0; EX_opcode = 7'h0; EX_regwrite = 1'b0;
    EX_r2 = 32'h0; EX_alu_result = 32'h0;
    bus.dmem_ack = 1'b0;
    bus.dmem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_req",      32'(bus.dmem_req),  32'h0);
    check("rst_addr",     bus.dmem_addr,      32'h0);
    check("rst_instr",    MEM_instr,          32'h0);
    check("rst_alu",      MEM_alu_result,     32'h0);
    check("rst_regwrite", 32'(MEM_regwrite),  32'h0);
    check("rst_fault",    32'(MEM_fault),     32'h0);
    check("rst_state",    32'(dbg_state),     32'h0);
    reset = 1'b1;
    @(negedge clk);

    // ADD pass-through
    apply(3'd0, OP_ADD, 5'd5, 1'b1, 32'h0, 32'h1234, 0, 32'h0);
    check("add_alu", MEM_alu_result, 32'h1234);
    check("add_rd",  32'(MEM_rd), 32'd5);
    check("add_lat", last_lat, 1);

    // LB / LBU with ack in the third ACCESS cycle
    apply(3'd0, OP_LOAD, 5'd7, 1'b1, 32'h0, 32'h103, 3, 32'h80FF_7F01);
    check("lb_data",  MEM_load_data, 32'hFFFF_FF80);
    check("lb_addr",  last_addr, 32'h100);
    check("lb_wstrb", 32'(last_wstrb), 32'h0);
    apply(3'd4, OP_LOAD, 5'd7, 1'b1, 32'h0, 32'h103, 3, 32'h80FF_7F01);
    check("lbu_data", MEM_load_data, 32'h0000_0080);

    // SH with immediate ack: 2-cycle latency
    apply(3'd1, OP_STORE, 5'd0, 1'b0, 32'hDEAD_BEEF, 32'h22, 1, 32'h0);
    check("sh_we",    32'(last_we), 32'h1);
    check("sh_wdata", last_wdata, 32'hBEEF_BEEF);
    check("sh_wstrb", 32'(last_wstrb), 32'hC);
    check("sh_lat",   last_lat, 2);

    // misaligned LW faults without a request
    apply(3'd2, OP_LOAD, 5'd9, 1'b1, 32'h0, 32'h6, 1, 32'h0);
    check("lw_mis_fault", 32'(MEM_fault), 32'h1);
    check("lw_mis_rw",    32'(MEM_regwrite), 32'h0);

    // timeout, then ack on the expiry cycle
    apply(3'd2, OP_LOAD, 5'd3, 1'b1, 32'h0, 32'h40, 0, 32'h0);
    check("to_req_cycles", last_req_cycles, 4);
    check("to_fault",      32'(MEM_fault), 32'h1);
    check("to_state",      32'(dbg_state), 32'h0);
    apply(3'd2, OP_LOAD, 5'd3, 1'b1, 32'h0, 32'h40, 4, 32'h1122_3344);
    check("ack4_fault", 32'(MEM_fault), 32'h0);
    check("ack4_data",  MEM_load_data, 32'h1122_3344);

    // remaining widths, illegal funct3, store regwrite forwarding
    apply(3'd1, OP_LOAD,  5'd4, 1'b1, 32'h0, 32'h102, 2, 32'h8001_1234);
    check("lh_data", MEM_load_data, 32'hFFFF_8001);
    apply(3'd5, OP_LOAD,  5'd4, 1'b1, 32'h0, 32'h100, 1, 32'h8001_F234);
    check("lhu_data", MEM_load_data, 32'h0000_F234);
    apply(3'd0, OP_STORE, 5'd0, 1'b0, 32'h1234_56A5, 32'h201, 2, 32'h0);
    check("sb_wstrb", 32'(last_wstrb), 32'h2);
    apply(3'd2, OP_STORE, 5'd1, 1'b1, 32'hCAFE_F00D, 32'h300, 1, 32'h0);
    check("sw_wdata", last_wdata, 32'hCAFE_F00D);
    apply(3'd3, OP_LOAD,  5'd2, 1'b1, 32'h0, 32'h0, 1, 32'h0);
    apply(3'd4, OP_STORE, 5'd2, 1'b0, 32'h0, 32'h0, 1, 32'h0);
    apply(3'd1, OP_LOAD,  5'd2, 1'b1, 32'h0, 32'h101, 1, 32'h0);
    apply(3'd0, OP_ADD,   5'd8, 1'b1, 32'h0, 32'h5A5A, 0, 32'h0);

    // asynchronous reset in the middle of an access
    EX_instr = {17'h0, 3'd2, 5'd6, OP_LOAD};
    EX_opcode = OP_LOAD; EX_rd = 5'd6; EX_regwrite = 1'b1; EX_alu_result = 32'h80;
    @(negedge clk);
    check("mid_req_up", 32'(bus.dmem_req), 32'h1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_req",   32'(bus.dmem_req), 32'h0);
    check("mid_rst_addr",  bus.dmem_addr, 32'h0);
    check("mid_rst_state", 32'(dbg_state), 32'h0);
    check("mid_rst_rw",    32'(MEM_regwrite), 32'h0);
    EX_opcode = 7'h0; EX_instr = 32'h0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    apply(3'd0, OP_ADD, 5'd11, 1'b1, 32'h0, 32'h0BAD_F00D, 0, 32'h0);
    check("post_rst_alu", MEM_alu_result, 32'h0BAD_F00D);
    check("post_rst_lat", last_lat, 1);

    EX_opcode = 7'h0; EX_instr = 32'h0;
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    n_err++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
